contador_mod6: RTL and testbench

CONTADOR_MOD6 -- requirements
Module: contador_mod6

---
 rtl/contador_mod6.sv | 36 +++
 tb/tb_contador_mod6.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/contador_mod6.sv
// Modulo-6 down counter for the tens-of-seconds digit: 5,4,3,2,1,0,5,...
// Supports a clamped parallel load and drives a borrow-out (tc) to the next digit stage.
module contador_mod6 (
    input  logic [3:0] data,
    input  logic       clk,
    input  logic       load,
    input  logic       en,
    input  logic       clearn,
    output logic [3:0] count,
    output logic       tc,
    output logic       count_end
);

    localparam logic [3:0] MAX_VAL = 4'd5;

    logic [3:0] load_val;
    logic       is_zero;

    // Out-of-range load values saturate to the top of the digit range.
    assign load_val = (data > MAX_VAL) ? MAX_VAL : data;
    assign is_zero  = (count == 4'd0);

    always_ff @(posedge clk) begin
        if (clearn) begin
            count <= 4'd0;
        end else if (!load) begin
            count <= load_val;
        end else if (en) begin
            count <= is_zero ? MAX_VAL : (count - 4'd1);
        end
    end

    assign count_end = is_zero;
    assign tc        = en & is_zero;

endmodule

// File: tb/tb_contador_mod6.sv
// Directed bench for contador_mod6: reset, clamped load, count/wrap,
// load priority, mid-count reset and enable gating of tc.
module tb_contador_mod6;

    logic [3:0] data;
    logic       clk;
    logic       load;
    logic       en;
    logic       clearn;
    logic [3:0] count;
    logic       tc;
    logic       count_end;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    contador_mod6 dut (
        .data      (data),
        .clk       (clk),
        .load      (load),
        .en        (en),
        .clearn    (clearn),
        .count     (count),
        .tc        (tc),
        .count_end (count_end)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clearn = 1'b1; load = 1'b0; en = 1'b1; data = 4'd3;
        tick();
        checks++;
        if (count !== 4'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", count);
        end
        checks++;
        if (count_end !== 1'b1) begin
            errors++; $display("FAIL reset_count_end: got %b expected 1", count_end);
        end
        checks++;
        if (tc !== 1'b1) begin
            errors++; $display("FAIL reset_tc: got %b expected 1", tc);
        end
    endtask

    task automatic test_clamped_load();
        clearn = 1'b0; load = 1'b0; en = 1'b0; data = 4'b0110;
        tick();
        checks++;
        if (count !== 4'd5) begin
            errors++; $display("FAIL clamp_load_6: got %0d expected 5", count);
        end
        load = 1'b1; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== 4'd5 || tc !== 1'b0 || count_end !== 1'b0) begin
                errors++;
                $display("FAIL hold_5[%0d]: got count=%0d tc=%b end=%b expected count=5 tc=0 end=0",
                         i, count, tc, count_end);
            end
        end
        // Maximum input value also saturates, and a legal value loads verbatim.
        load = 1'b0; data = 4'd15;
        tick();
        checks++;
        if (count !== 4'd5) begin
            errors++; $display("FAIL clamp_load_15: got %0d expected 5", count);
        end
        data = 4'd1;
        tick();
        checks++;
        if (count !== 4'd1) begin
            errors++; $display("FAIL load_1: got %0d expected 1", count);
        end
        data = 4'd5;
        tick();
        checks++;
        if (count !== 4'd5) begin
            errors++; $display("FAIL load_5: got %0d expected 5", count);
        end
        load = 1'b1;
    endtask

    task automatic test_count_wrap();
        logic [3:0] exp_c;
        exp_q = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5, 4'd4};
        load = 1'b1; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_c = exp_q.pop_front();
            checks++;
            if (count !== exp_c) begin
                errors++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, count, exp_c);
            end
            checks++;
            if (tc !== (exp_c == 4'd0) || count_end !== (exp_c == 4'd0)) begin
                errors++;
                $display("FAIL wrap_flags[%0d]: got tc=%b end=%b expected both %b",
                         i, tc, count_end, (exp_c == 4'd0));
            end
        end
    endtask

    task automatic test_load_priority();
        // From 4, two enabled edges bring the counter to 2.
        tick();
        tick();
        checks++;
        if (count !== 4'd2) begin
            errors++; $display("FAIL pre_load_count: got %0d expected 2", count);
        end
        load = 1'b0; en = 1'b1; data = 4'd4;
        tick();
        checks++;
        if (count !== 4'd4) begin
            errors++; $display("FAIL load_priority: got %0d expected 4", count);
        end
        load = 1'b1;
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        tick();
        checks++;
        if (count !== 4'd3) begin
            errors++; $display("FAIL mid_pre: got %0d expected 3", count);
        end
        clearn = 1'b1; load = 1'b0;
        tick();
        checks++;
        if (count !== 4'd0) begin
            errors++; $display("FAIL mid_reset: got %0d expected 0", count);
        end
        clearn = 1'b0; load = 1'b1; en = 1'b1;
        tick();
        checks++;
        if (count !== 4'd5) begin
            errors++; $display("FAIL mid_resume: got %0d expected 5", count);
        end
    endtask

    task automatic test_tc_gating();
        clearn = 1'b1;
        tick();
        clearn = 1'b0; load = 1'b1; en = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (count !== 4'd0 || tc !== 1'b0 || count_end !== 1'b1) begin
                errors++;
                $display("FAIL gate_hold[%0d]: got count=%0d tc=%b end=%b expected count=0 tc=0 end=1",
                         i, count, tc, count_end);
            end
            tick();
        end
        // tc follows en combinationally with no clock edge.
        en = 1'b1;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++; $display("FAIL gate_tc_comb: got %b expected 1", tc);
        end
    endtask

    initial begin
        data = 4'd0; load = 1'b1; en = 1'b0; clearn = 1'b1;
        #2;
        test_reset();
        test_clamped_load();
        test_count_wrap();
        test_load_priority();
        test_reset_mid();
        test_tc_gating();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
